ov7670_window_capture: RTL and testbench
========================================

Name: ov7670_window_capture

Overview:
Parametrised OV7670 capture engine. Pairs sensor bytes into 16-bit pixels (RGB565/YUV422), crops a programmable window and decimates by 2^DECIM_LOG2 in X and Y. Writes the pixels linearly into a framebuffer through a write strobe. Sits between the OV7670 pins and the framebuffer BRAM; runs single-shot or continuous frames under a start/busy/done handshake.

Parameters:
SENSOR_W, 640, active pixels per line from sensor
SENSOR_H, 480, active lines per frame from sensor
WIN_X0, 0, first captured pixel column (sensor pixel units)
WIN_Y0, 0, first captured line
WIN_W, 640, window width in sensor pixels; multiple of 2^DECIM_LOG2
WIN_H, 480, window height in sensor lines; multiple of 2^DECIM_LOG2
DECIM_LOG2, 2, decimation factor exponent (0..3) for both axes
ADDR_W, 15, framebuffer address width; 2^ADDR_W >= (WIN_W*WIN_H)>>(2*DECIM_LOG2)

Ports:
pclk_24  in  1  24 MHz sensor pixel clock
reset_n  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse: arm capture
continuous  in  1  sampled at start; 1 = capture every frame until stop
stop  in  1  one-cycle pulse: finish current frame, then return to IDLE
vsync  in  1  sensor vertical sync, high between frames
href  in  1  sensor line valid
d  in  8  sensor byte
wr_en  out  1  framebuffer write strobe
wr_addr  out  ADDR_W  framebuffer word address
wr_data  out  16  pixel {first byte, second byte}
busy  out  1  high from accepted start until return to IDLE
frame_done  out  1  one-cycle pulse after last window pixel written
err  out  1  sticky; set on malformed frame, cleared on accepted start

Behaviour:
- Reset: all outputs 0; FSM to IDLE; all counters 0. Reset mid-frame aborts the frame with no further writes.
- FSM: IDLE -start-> ARM (busy=1). ARM -vsync rise-> SYNC. SYNC -vsync fall-> ACTIVE. ACTIVE -vsync rise-> DONE.
- DONE lasts 1 cycle and pulses frame_done. It then goes to SYNC if continuous mode is latched and no stop is pending, else to IDLE.
- start is ignored when not IDLE. stop is latched while busy. stop in ARM returns to IDLE immediately, with no frame_done.
- Byte pairing: byte toggle resets at every href rise. The even byte is held; the odd byte completes a pixel. One pixel per 2 href-high cycles.
- Counters: px_x counts completed pixels within the line and resets at href rise. ln_y increments on href fall and resets on vsync fall.
- A pixel is written iff all of the following hold:
  - WIN_X0 <= px_x < WIN_X0+WIN_W
  - WIN_Y0 <= ln_y < WIN_Y0+WIN_H
  - (px_x-WIN_X0) and (ln_y-WIN_Y0) low DECIM_LOG2 bits are all zero
- Write timing: wr_en pulses 1 cycle after the odd byte, with wr_data/wr_addr valid in the same cycle. Latency from odd byte sampled to wr_en is 1 pclk.
- wr_addr: 0 for the first write of each frame, +1 per write. Held (not incremented) when it would exceed the window pixel count minus 1; such writes are suppressed and set err.
- err sets on any of:
  - href falls with an odd byte pending
  - line length ≠ SENSOR_W
  - vsync rises mid-href
  - write count at DONE ≠ (WIN_W*WIN_H)>>(2*DECIM_LOG2)
- vsync rising while href is high terminates the line; the frame proceeds to DONE.
- Simultaneous start and stop in IDLE: start wins, stop is discarded.

Optional Feature:
OV7670_FRAME_STATS_EN:
- Defined: adds outputs frame_cnt[15:0] (increments at each DONE, wraps at 0xFFFF→0) and last_lines[9:0] (ln_y latched at vsync rise). Both reset to 0.
- Undefined: ports and counters absent; core behaviour identical.

Decomposition:
- Shared package ov7670_pkg holds:
  - FSM state encoding (IDLE, ARM, SYNC, ACTIVE, DONE)
  - default SENSOR_W/H constants for VGA/QVGA/QCIF
  - a function computing window pixel count
- One natural sub-module: ov7670_byte_pair. It turns href/d into pixel_valid/pixel[15:0]/px_x, resets at href rise and flags the odd-byte error.

Test Plan:
- Default params, one 640x480 frame, bytes = incrementing counter:
  - exactly 19200 writes, addresses 0..19199
  - first wr_data = 0x0001 from sensor pixel (0,0)
  - frame_done once, err=0
- WIN_X0=16, WIN_Y0=8, WIN_W=32, WIN_H=16, DECIM_LOG2=1:
  - 128 writes
  - first pixel is sensor (16,8), second is (18,8)
- continuous=1, 3 frames, stop pulsed during frame 2:
  - frame_done pulses exactly 2 times, busy falls after the second
  - wr_addr restarts at 0 each frame
- Line of 1279 bytes (odd) mid-frame: err=1 after href fall; stays 1 until next start, then 0.
- reset_n low for 1 cycle at pixel 5000: outputs 0 immediately, no writes until a new start plus vsync cycle.
- start while busy: ignored, no addr reset. vsync rise during href: err=1, frame_done still pulses.

Source files
------------

// File: rtl/ov7670_pkg.sv
// Shared types and constants for the OV7670 window capture engine.
package ov7670_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_SYNC,
    ST_ACTIVE,
    ST_DONE
  } cap_state_t;

  localparam int VGA_W  = 640;
  localparam int VGA_H  = 480;
  localparam int QVGA_W = 320;
  localparam int QVGA_H = 240;
  localparam int QCIF_W = 176;
  localparam int QCIF_H = 144;

  // Width of pixel/line counters; covers sensors up to 4095 pixels per axis.
  localparam int CNT_W = 12;

  function automatic int win_pix_count(input int w, input int h, input int decim_log2);
    return (w * h) >> (2 * decim_log2);
  endfunction

endpackage

// File: rtl/ov7670_byte_pair.sv
// Pairs sensor bytes into 16-bit pixels; counts pixels per line and flags
// malformed line endings (odd byte pending, wrong pixel count).
module ov7670_byte_pair
  import ov7670_pkg::*;
#(
  parameter int SENSOR_W = 640
) (
  input  logic             pclk_24,
  input  logic             reset_n,
  input  logic             href,
  input  logic [7:0]       d,
  output logic             pixel_valid,
  output logic [15:0]      pixel,
  output logic [CNT_W-1:0] px_x,
  output logic             line_end,
  output logic             odd_err,
  output logic             len_err
);

  logic             href_q;
  logic             tog;
  logic [7:0]       hi;
  logic [CNT_W-1:0] cnt;
  logic             rise;

  assign rise     = href & ~href_q;
  assign line_end = ~href & href_q;
  assign odd_err  = line_end & tog;
  assign len_err  = line_end & (cnt != CNT_W'(SENSOR_W));

  always_ff @(posedge pclk_24 or negedge reset_n) begin
    if (!reset_n) begin
      href_q      <= 1'b0;
      tog         <= 1'b0;
      hi          <= '0;
      cnt         <= '0;
      pixel_valid <= 1'b0;
      pixel       <= '0;
      px_x        <= '0;
    end else begin
      href_q      <= href;
      pixel_valid <= 1'b0;
      if (href) begin
        // href rise always starts a fresh pair, discarding any stale half-pixel
        if (rise || !tog) begin
          hi  <= d;
          tog <= 1'b1;
          if (rise) cnt <= '0;
        end else begin
          pixel       <= {hi, d};
          pixel_valid <= 1'b1;
          px_x        <= cnt;
          cnt         <= cnt + 1'b1;
          tog         <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/ov7670_window_capture.sv
// OV7670 capture: crop + decimate into a linear framebuffer, single-shot or
// continuous. Define OV7670_FRAME_STATS_EN to add frame_cnt/last_lines outputs.
module ov7670_window_capture
  import ov7670_pkg::*;
#(
  parameter int SENSOR_W   = 640,
  parameter int SENSOR_H   = 480,
  parameter int WIN_X0     = 0,
  parameter int WIN_Y0     = 0,
  parameter int WIN_W      = 640,
  parameter int WIN_H      = 480,
  parameter int DECIM_LOG2 = 2,
  parameter int ADDR_W     = 15
) (
  input  logic              pclk_24,
  input  logic              reset_n,
  input  logic              start,
  input  logic              continuous,
  input  logic              stop,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        d,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              err
`ifdef OV7670_FRAME_STATS_EN
  ,
  output logic [15:0]       frame_cnt,
  output logic [9:0]        last_lines
`endif
);

  localparam int               NPIX  = win_pix_count(WIN_W, WIN_H, DECIM_LOG2);
  localparam logic [CNT_W-1:0] DMASK = CNT_W'((1 << DECIM_LOG2) - 1);

  cap_state_t       state, nstate;
  logic             vsync_q, cont_q, stop_pend;
  logic [CNT_W-1:0] ln_y, dx, dy;
  logic [ADDR_W:0]  wr_cnt;
  logic             vs_rise, vs_fall, in_win, room;

  logic             pixel_valid, line_end, odd_err, len_err;
  logic [15:0]      pixel;
  logic [CNT_W-1:0] px_x;

  ov7670_byte_pair #(.SENSOR_W(SENSOR_W)) u_pair (
    .pclk_24    (pclk_24),
    .reset_n    (reset_n),
    .href       (href),
    .d          (d),
    .pixel_valid(pixel_valid),
    .pixel      (pixel),
    .px_x       (px_x),
    .line_end   (line_end),
    .odd_err    (odd_err),
    .len_err    (len_err)
  );

  assign vs_rise = vsync & ~vsync_q;
  assign vs_fall = ~vsync & vsync_q;
  assign dx      = px_x - CNT_W'(WIN_X0);
  assign dy      = ln_y - CNT_W'(WIN_Y0);
  assign in_win  = pixel_valid && (state == ST_ACTIVE)
                && (px_x >= CNT_W'(WIN_X0)) && (px_x < CNT_W'(WIN_X0 + WIN_W))
                && (ln_y >= CNT_W'(WIN_Y0)) && (ln_y < CNT_W'(WIN_Y0 + WIN_H))
                && ((dx & DMASK) == '0) && ((dy & DMASK) == '0);
  assign room    = wr_cnt < (ADDR_W+1)'(NPIX);

  assign wr_en      = in_win & room;
  assign wr_addr    = wr_en ? wr_cnt[ADDR_W-1:0] : '0;
  assign wr_data    = wr_en ? pixel : '0;
  assign busy       = (state != ST_IDLE);
  assign frame_done = (state == ST_DONE);

  always_comb begin
    nstate = state;
    case (state)
      ST_IDLE:   if (start) nstate = ST_ARM;
      ST_ARM:    if (stop || stop_pend) nstate = ST_IDLE;
                 else if (vs_rise) nstate = ST_SYNC;
      ST_SYNC:   if (vs_fall) nstate = ST_ACTIVE;
      ST_ACTIVE: if (vs_rise) nstate = ST_DONE;
      ST_DONE:   nstate = (cont_q && !stop_pend && !stop) ? ST_SYNC : ST_IDLE;
      default:   nstate = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk_24 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      vsync_q   <= 1'b0;
      cont_q    <= 1'b0;
      stop_pend <= 1'b0;
      ln_y      <= '0;
      wr_cnt    <= '0;
      err       <= 1'b0;
    end else begin
      state   <= nstate;
      vsync_q <= vsync;
      if (state == ST_IDLE && start) begin
        cont_q    <= continuous;
        stop_pend <= 1'b0;
      end else if (busy && stop) begin
        stop_pend <= 1'b1;
      end
      if (vs_fall) ln_y <= '0;
      else if (line_end) ln_y <= ln_y + 1'b1;
      if (state == ST_SYNC && vs_fall) wr_cnt <= '0;
      else if (wr_en) wr_cnt <= wr_cnt + 1'b1;
      // overflowing writes are dropped but still mark the frame as bad
      if (state == ST_IDLE && start)
        err <= 1'b0;
      else if (state == ST_ACTIVE &&
               (odd_err || len_err || (vs_rise && href) || (in_win && !room)))
        err <= 1'b1;
      else if (state == ST_DONE && wr_cnt != (ADDR_W+1)'(NPIX))
        err <= 1'b1;
    end
  end

`ifdef OV7670_FRAME_STATS_EN
  always_ff @(posedge pclk_24 or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt  <= '0;
      last_lines <= '0;
    end else begin
      if (state == ST_DONE) frame_cnt <= frame_cnt + 1'b1;
      if (vs_rise) last_lines <= ln_y[9:0];
    end
  end
`endif

endmodule

// File: tb/tb_ov7670_window_capture.sv
// Scoreboard bench: driver pushes expected writes, monitor pops on wr_en.
module tb_ov7670_window_capture;
  localparam int SW = 16, SH = 12, X0 = 4, Y0 = 2, WW = 8, WH = 8, DL = 1, AW = 4, NP = 16;

  logic pclk_24 = 0, reset_n = 0, start = 0, continuous = 0, stop = 0, vsync = 0, href = 0;
  logic [7:0] d = 0;
  logic wr_en, busy, frame_done, err;
  logic [AW-1:0] wr_addr;
  logic [15:0] wr_data;
`ifdef OV7670_FRAME_STATS_EN
  logic [15:0] frame_cnt;
  logic [9:0]  last_lines;
`endif

  ov7670_window_capture #(
    .SENSOR_W(SW), .SENSOR_H(SH), .WIN_X0(X0), .WIN_Y0(Y0),
    .WIN_W(WW), .WIN_H(WH), .DECIM_LOG2(DL), .ADDR_W(AW)
  ) dut (
    .pclk_24(pclk_24), .reset_n(reset_n), .start(start), .continuous(continuous),
    .stop(stop), .vsync(vsync), .href(href), .d(d),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .frame_done(frame_done), .err(err)
`ifdef OV7670_FRAME_STATS_EN
    , .frame_cnt(frame_cnt), .last_lines(last_lines)
`endif
  );

  initial forever #5 pclk_24 = ~pclk_24;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [15:0]   dat;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] act_log[$];
  int checks = 0, failures = 0, fd_cnt = 0, bc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge pclk_24) begin
    if (reset_n) begin
      if (wr_en) begin
        act_log.push_back(wr_data);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected no write", wr_addr, wr_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("wr_addr", 32'(wr_addr), 32'(e.a));
          chk("wr_data", 32'(wr_data), 32'(e.dat));
        end
      end
      if (frame_done) fd_cnt++;
    end
  end

  task automatic tick();
    @(posedge pclk_24);
    #1;
  endtask

  task automatic vs_pulse();
    vsync = 1; repeat (4) tick();
    vsync = 0; repeat (4) tick();
  endtask

  task automatic pulse_start(input logic cont);
    start = 1; continuous = cont; tick(); start = 0;
  endtask

  // One frame: vsync pulse then SH lines; the closing vsync rise comes from the caller.
  task automatic run_frame(input bit cap, input int odd_line, input int stop_line,
                           input int start_line, input int rst_line, input bit vs_cut);
    int cnt = 0;
    int nb, x;
    bit c = cap;
    logic [7:0] prev = 0;
    vs_pulse();
    bc = 0;
    for (int y = 0; y < SH; y++) begin
      if (y == rst_line) begin
        reset_n = 0; #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        tick(); reset_n = 1; c = 0;
      end
      if (y == stop_line) begin stop = 1; tick(); stop = 0; end
      if (y == start_line) begin start = 1; tick(); start = 0; end
      nb = (y == odd_line) ? 2*SW - 1 : (vs_cut && y == SH-1) ? 10 : 2*SW;
      for (int b = 0; b < nb; b++) begin
        href = 1; d = bc[7:0];
        if (b % 2 == 1 && c) begin
          x = b / 2;
          if (x >= X0 && x < X0+WW && (x-X0) % (1<<DL) == 0 &&
              y >= Y0 && y < Y0+WH && (y-Y0) % (1<<DL) == 0 && cnt < NP) begin
            exp_q.push_back('{a: cnt[AW-1:0], dat: {prev, bc[7:0]}});
            cnt++;
          end
        end
        prev = bc[7:0]; bc++;
        tick();
      end
      if (vs_cut && y == SH-1) begin
        vsync = 1; tick(); href = 0;
        repeat (4) tick(); vsync = 0; repeat (4) tick();
      end else begin
        href = 0; repeat (3) tick();
        if (y == odd_line) chk("err_after_odd_line", 32'(err), 1);
      end
    end
  endtask

  initial begin
    int f0;
    logic [15:0] a0, a1, a15;
    repeat (3) tick();
    chk("reset_wr_en", 32'(wr_en), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_frame_done", 32'(frame_done), 0);
    chk("reset_err", 32'(err), 0);
    chk("reset_wr_addr", 32'(wr_addr), 0);
    chk("reset_wr_data", 32'(wr_data), 0);
    reset_n = 1; tick();

    // single-shot frame
    pulse_start(0);
    chk("busy_after_start", 32'(busy), 1);
    f0 = fd_cnt; act_log.delete();
    run_frame(1, -1, -1, -1, -1, 0);
    vs_pulse();
    chk("t1_frame_done", 32'(fd_cnt - f0), 1);
    chk("t1_err", 32'(err), 0);
    chk("t1_busy", 32'(busy), 0);
    chk("t1_writes", 32'(act_log.size()), 16);
    a0  = (act_log.size() > 0)  ? act_log[0]  : 16'h0;
    a1  = (act_log.size() > 1)  ? act_log[1]  : 16'h0;
    a15 = (act_log.size() > 15) ? act_log[15] : 16'h0;
    chk("t1_first_px_4_2", 32'(a0), 32'h4849);
    chk("t1_second_px_6_2", 32'(a1), 32'h4C4D);
    chk("t1_last_px_10_8", 32'(a15), 32'h1415);

    // continuous, stop during frame 2
    pulse_start(1);
    f0 = fd_cnt;
    run_frame(1, -1, -1, -1, -1, 0);
    run_frame(1, -1, 3, -1, -1, 0);
    run_frame(0, -1, -1, -1, -1, 0);
    chk("cont_frame_done", 32'(fd_cnt - f0), 2);
    chk("cont_busy", 32'(busy), 0);
    chk("cont_err", 32'(err), 0);

    // odd-length line; err sticky until next start; stop in ARM
    pulse_start(0);
    f0 = fd_cnt;
    run_frame(1, 5, -1, -1, -1, 0);
    vs_pulse();
    chk("odd_err_sticky", 32'(err), 1);
    chk("odd_frame_done", 32'(fd_cnt - f0), 1);
    pulse_start(0);
    chk("err_cleared_by_start", 32'(err), 0);
    chk("armed_busy", 32'(busy), 1);
    stop = 1; tick(); stop = 0; tick();
    chk("stop_in_arm_busy", 32'(busy), 0);
    chk("stop_in_arm_no_done", 32'(fd_cnt - f0), 1);

    // reset mid-frame, then recover
    pulse_start(0);
    f0 = fd_cnt;
    run_frame(1, -1, -1, -1, 4, 0);
    vs_pulse();
    chk("rst_no_done", 32'(fd_cnt - f0), 0);
    chk("rst_idle", 32'(busy), 0);
    pulse_start(0);
    run_frame(1, -1, -1, -1, -1, 0);
    vs_pulse();
    chk("rst_recover_done", 32'(fd_cnt - f0), 1);
    chk("rst_recover_err", 32'(err), 0);

    // start while busy is ignored
    pulse_start(0);
    f0 = fd_cnt;
    run_frame(1, -1, -1, 6, -1, 0);
    vs_pulse();
    chk("busy_start_done", 32'(fd_cnt - f0), 1);
    chk("busy_start_err", 32'(err), 0);

    // vsync rises while href high
    pulse_start(0);
    f0 = fd_cnt;
    run_frame(1, -1, -1, -1, -1, 1);
    chk("vs_cut_err", 32'(err), 1);
    chk("vs_cut_done", 32'(fd_cnt - f0), 1);
    chk("vs_cut_busy", 32'(busy), 0);

    // start and stop together in IDLE: start wins
    start = 1; stop = 1; tick(); start = 0; stop = 0; tick();
    chk("start_wins_busy", 32'(busy), 1);
    stop = 1; tick(); stop = 0; tick();
    chk("final_stop_busy", 32'(busy), 0);

    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
